// File: rtl/fp_mul_arbiter.sv
// Two requesters share one signed fixed-point multiplier: a round-robin grant feeds
// an issue register, and the product is formatted and latched in a response register.
module fp_mul_arbiter #(
  parameter int WI1 = 4,
  parameter int WF1 = 5,
  parameter int WI2 = 4,
  parameter int WF2 = 5,
  parameter int WIO = 8,
  parameter int WFO = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WI1+WF1-1:0]   req0_a,
  input  logic [WI2+WF2-1:0]   req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WI1+WF1-1:0]   req1_a,
  input  logic [WI2+WF2-1:0]   req1_b,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [WIO+WFO-1:0]   rsp_data,
  output logic                 rsp_ovf,
  output logic [1:0]           ovf_sticky,
  input  logic [1:0]           clr_ovf
);

  localparam int AW     = WI1 + WF1;
  localparam int BW     = WI2 + WF2;
  localparam int INT_L  = WI1 + WI2;
  localparam int FRAC_L = WF1 + WF2;
  localparam int PW     = INT_L + FRAC_L;

  logic last_grant;
  logic grant0;
  logic grant1;
  logic xfer;
  logic xfer_id;

  // Handshake: an operand pair moves when reqN_valid and reqN_ready are both high at
  // a rising edge; ready is the grant itself, so a requester may drop valid at any time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign xfer_id    = grant1;

  logic                  s1_valid;
  logic                  s1_id;
  logic signed [AW-1:0]  s1_a;
  logic signed [BW-1:0]  s1_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      last_grant <= 1'b1;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_a       <= xfer_id ? req1_a : req0_a;
        s1_b       <= xfer_id ? req1_b : req0_b;
        s1_id      <= xfer_id;
        last_grant <= xfer_id;
      end
    end
  end

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic [INT_L-1:0]     int_p;
  logic [WFO-1:0]       frac_f;
  logic [WIO-1:0]       int_f;
  logic                 ovf;

  assign a_ext = PW'(s1_a);
  assign b_ext = PW'(s1_b);
  assign prod  = a_ext * b_ext;
  assign int_p = prod[PW-1:FRAC_L];

  generate
    if (WFO == FRAC_L) begin : g_frac_exact
      assign frac_f = prod[FRAC_L-1:0];
    end else if (WFO > FRAC_L) begin : g_frac_pad
      assign frac_f = {prod[FRAC_L-1:0], {(WFO-FRAC_L){1'b0}}};
    end else begin : g_frac_trunc
      // Low fraction bits fall off: plain truncation toward minus infinity.
      logic unused_frac;
      assign frac_f      = prod[FRAC_L-1 -: WFO];
      assign unused_frac = ^prod[FRAC_L-WFO-1:0];
    end
  endgenerate

  generate
    if (WIO == INT_L) begin : g_int_exact
      assign int_f = int_p;
      assign ovf   = 1'b0;
    end else if (WIO > INT_L) begin : g_int_ext
      assign int_f = {{(WIO-INT_L){int_p[INT_L-1]}}, int_p};
      assign ovf   = 1'b0;
    end else begin : g_int_trunc
      // Keep the true sign bit; the dropped upper bits must all match it to be exact.
      assign int_f = {int_p[INT_L-1], int_p[WIO-2:0]};
      assign ovf   = !((&int_p[INT_L-1:WIO-1]) || !(|int_p[INT_L-1:WIO-1]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_ovf    <= 1'b0;
      ovf_sticky <= 2'b00;
    end else begin
      rsp0_valid <= s1_valid && !s1_id;
      rsp1_valid <= s1_valid && s1_id;
      if (s1_valid) begin
        rsp_data <= {int_f, frac_f};
        rsp_ovf  <= ovf;
      end
      // A set from the response on the bus this cycle beats a same-cycle clear.
      ovf_sticky <= (ovf_sticky & ~clr_ovf) | ({rsp1_valid, rsp0_valid} & {2{rsp_ovf}});
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: two instances (default format and Q4.4 output) share
// one stimulus stream and are checked every cycle against an arithmetic model.
module tb_fp_mul_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [8:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] clr_ovf;

  logic        u0_ready0, u0_ready1, u0_rsp0, u0_rsp1, u0_ovf;
  logic [17:0] u0_data;
  logic [1:0]  u0_sticky;
  logic        u1_ready0, u1_ready1, u1_rsp0, u1_rsp1, u1_ovf;
  logic [7:0]  u1_data;
  logic [1:0]  u1_sticky;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter u0 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(u0_ready0), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(u0_ready1), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(u0_rsp0), .rsp1_valid(u0_rsp1), .rsp_data(u0_data), .rsp_ovf(u0_ovf),
    .ovf_sticky(u0_sticky), .clr_ovf(clr_ovf)
  );

  fp_mul_arbiter #(.WIO(4), .WFO(4)) u1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(u1_ready0), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(u1_ready1), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(u1_rsp0), .rsp1_valid(u1_rsp1), .rsp_data(u1_data), .rsp_ovf(u1_ovf),
    .ovf_sticky(u1_sticky), .clr_ovf(clr_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Real-valued view: product scaled to the output fraction, floor on truncation,
  // flagged when outside the signed output range, sign bit kept from the product.
  function automatic void ref_mul(input logic [8:0] a, input logic [8:0] b,
                                  input int wio, input int wfo,
                                  output longint res, output logic ovf);
    longint p, s, hi, lo;
    int ow;
    p  = longint'($signed(a)) * longint'($signed(b));
    if (wfo >= 10) s = p <<< (wfo - 10);
    else           s = p >>> (10 - wfo);
    ow  = wio + wfo;
    hi  = (longint'(1) << (ow - 1)) - 1;
    lo  = -(longint'(1) << (ow - 1));
    ovf = (s > hi) || (s < lo);
    res = s & hi;
    if (p < 0) res = res | (longint'(1) << (ow - 1));
  endfunction

  function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  typedef struct {
    int         due;
    logic       id;
    logic [8:0] a;
    logic [8:0] b;
  } op_t;

  op_t         exp_q[$];
  int          cyc = 0;
  logic        m_last = 1'b1;
  logic        m_vis = 1'b0;
  logic        m_id = 1'b0;
  logic [31:0] m_data[2];
  logic        m_ovf[2];
  logic [1:0]  m_sticky[2];
  op_t         m_op;
  logic [1:0]  m_g;
  longint      m_r;
  logic        m_o;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      m_last = 1'b1;
      m_vis  = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_data[i]   = 32'd0;
        m_ovf[i]    = 1'b0;
        m_sticky[i] = 2'b00;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        m_sticky[i] = (m_sticky[i] & ~clr_ovf) | ((m_vis && m_ovf[i]) ? (2'b01 << m_id) : 2'b00);
      m_vis = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        m_op  = exp_q.pop_front();
        m_vis = 1'b1;
        m_id  = m_op.id;
        ref_mul(m_op.a, m_op.b, 8, 10, m_r, m_o);
        m_data[0] = m_r[31:0];
        m_ovf[0]  = m_o;
        ref_mul(m_op.a, m_op.b, 4, 4, m_r, m_o);
        m_data[1] = m_r[31:0];
        m_ovf[1]  = m_o;
      end
      m_g = exp_grant(req0_valid, req1_valid, m_last);
      if (m_g != 2'b00) begin
        m_op.due = cyc + 1;
        m_op.id  = m_g[1];
        m_op.a   = m_g[1] ? req1_a : req0_a;
        m_op.b   = m_g[1] ? req1_b : req0_b;
        exp_q.push_back(m_op);
        m_last = m_g[1];
      end
    end
  end

  logic [1:0] c_g;
  always @(negedge clk) begin
    if (cyc > 0) begin
      c_g = reset ? 2'b00 : exp_grant(req0_valid, req1_valid, m_last);
      check("u0.req0_ready", u0_ready0, c_g[0]);
      check("u0.req1_ready", u0_ready1, c_g[1]);
      check("u1.req0_ready", u1_ready0, c_g[0]);
      check("u1.req1_ready", u1_ready1, c_g[1]);
      check("u0.rsp0_valid", u0_rsp0, m_vis && !m_id);
      check("u0.rsp1_valid", u0_rsp1, m_vis && m_id);
      check("u1.rsp0_valid", u1_rsp0, m_vis && !m_id);
      check("u1.rsp1_valid", u1_rsp1, m_vis && m_id);
      check("u0.rsp_data", u0_data, m_data[0]);
      check("u1.rsp_data", u1_data, m_data[1]);
      check("u0.rsp_ovf", u0_ovf, m_ovf[0]);
      check("u1.rsp_ovf", u1_ovf, m_ovf[1]);
      check("u0.ovf_sticky", u0_sticky, m_sticky[0]);
      check("u1.ovf_sticky", u1_sticky, m_sticky[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin_model(input logic [8:0] a, input logic [8:0] b, input int wio, input int wfo,
                           input logic [31:0] exp_res, input logic exp_ovf);
    longint r;
    logic   o;
    ref_mul(a, b, wio, wfo, r, o);
    check("model.res", r[31:0], exp_res);
    check("model.ovf", o, exp_ovf);
  endtask

  task automatic issue(input logic id, input logic [8:0] a, input logic [8:0] b);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    check(id ? "issue.req1_ready" : "issue.req0_ready", id ? u0_ready1 : u0_ready0, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    clr_ovf = 2'b00;

    pin_model(9'h020, 9'h050, 8, 10, 32'h00A00, 1'b0);
    pin_model(9'h1E0, 9'h010, 8, 10, 32'h3FE00, 1'b0);
    pin_model(9'h0E0, 9'h0E0, 4, 4, 32'h10, 1'b1);

    repeat (3) tick();
    check("reset.u0_data", u0_data, 18'h0);
    check("reset.u0_sticky", u0_sticky, 2'b00);
    reset = 1'b0;

    issue(1'b0, 9'h020, 9'h050);
    tick();
    check("single.rsp0_valid", u0_rsp0, 1'b1);
    check("single.rsp1_valid", u0_rsp1, 1'b0);
    check("single.rsp_data", u0_data, 18'h00A00);
    check("single.rsp_ovf", u0_ovf, 1'b0);

    issue(1'b1, 9'h1E0, 9'h010);
    tick();
    check("neg.rsp1_valid", u0_rsp1, 1'b1);
    check("neg.rsp_data", u0_data, 18'h3FE00);
    check("neg.rsp_ovf", u0_ovf, 1'b0);

    issue(1'b0, 9'h0E0, 9'h0E0);
    tick();
    check("ovf.rsp_data", u1_data, 8'h10);
    check("ovf.rsp_ovf", u1_ovf, 1'b1);
    tick();
    check("ovf.sticky", u1_sticky, 2'b01);
    clr_ovf = 2'b01;
    tick();
    clr_ovf = 2'b00;
    check("ovf.sticky_clr", u1_sticky, 2'b00);

    // Contention straight out of reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 9'($urandom); req0_b = 9'($urandom);
      req1_a = 9'($urandom); req1_b = 9'($urandom);
      #1;
      check("contend.req0_ready", u0_ready0, (i % 2) == 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    // Reset lands one edge after the accepting edge.
    issue(1'b0, 9'h020, 9'h050);
    reset = 1'b1;
    tick();
    check("midreset.rsp0_valid", u0_rsp0, 1'b0);
    check("midreset.rsp_data", u0_data, 18'h0);
    reset = 1'b0;
    tick();
    check("midreset.rsp0_after", u0_rsp0, 1'b0);

    // Clear coincides with an overflowing response.
    issue(1'b0, 9'h0E0, 9'h0E0);
    tick();
    clr_ovf = 2'b01;
    tick();
    clr_ovf = 2'b00;
    check("collide.sticky0", u1_sticky[0], 1'b1);
    clr_ovf = 2'b01;
    tick();
    clr_ovf = 2'b00;

    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 9'($urandom); req0_b = 9'($urandom);
      req1_a = 9'($urandom); req1_b = 9'($urandom);
      clr_ovf = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      tick();
    end
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; clr_ovf = 2'b00;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
